// File: rtl/dsp48a1_slice_pkg.sv
// dsp48a1_slice_pkg: OPMODE bit positions and X/Z operand mux encodings
package dsp48a1_slice_pkg;

    localparam int OP_PRE_SEL  = 4;
    localparam int OP_CARRY    = 5;
    localparam int OP_PRE_SUB  = 6;
    localparam int OP_POST_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } zsel_e;

endpackage

// File: rtl/dsp48a1_slice_stage.sv
// stage_reg: one optional pipeline stage, registered when REG != 0, wire otherwise
module stage_reg #(
    parameter int WIDTH = 1,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r;

    // async clear has priority over the clock enable
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r <= '0;
        else if (ce)
            r <= d;

    assign q = (REG != 0) ? r : d;

endmodule

// File: rtl/dsp48a1_slice.sv
// dsp48a1_slice: pre-adder, 18x18 multiplier and 48-bit post-adder with optional pipeline stages
module dsp48a1_slice
    import dsp48a1_slice_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [17:0] BCIN,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [17:0] BCOUT,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    logic [7:0]  op;
    logic [17:0] d_q, b0_q, a0_q, a1_q, b1_q, pre, b1_in;
    logic [47:0] c_q, x, z;
    logic [35:0] m_q;
    logic        cin, cin_q, co_q;
    logic [48:0] post;

    stage_reg #(.WIDTH(8),  .REG(OPMODEREG)) u_op (.clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op));
    stage_reg #(.WIDTH(18), .REG(DREG))      u_d  (.clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_q));
    stage_reg #(.WIDTH(18), .REG(B0REG))     u_b0 (.clk(CLK), .rst_n(RSTB), .ce(CEB), .d(B_INPUT == "CASCADE" ? BCIN : B), .q(b0_q));
    stage_reg #(.WIDTH(18), .REG(A0REG))     u_a0 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0_q));
    stage_reg #(.WIDTH(18), .REG(A1REG))     u_a1 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));
    stage_reg #(.WIDTH(18), .REG(B1REG))     u_b1 (.clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b1_in), .q(b1_q));
    stage_reg #(.WIDTH(48), .REG(CREG))      u_c  (.clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_q));
    stage_reg #(.WIDTH(36), .REG(MREG))      u_m  (.clk(CLK), .rst_n(RSTM), .ce(CEM), .d(36'(a1_q * b1_q)), .q(m_q));
    stage_reg #(.WIDTH(1),  .REG(CARRYINREG))  u_ci (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(cin), .q(cin_q));
    stage_reg #(.WIDTH(48), .REG(PREG))        u_p  (.clk(CLK), .rst_n(RSTP), .ce(CEP), .d(post[47:0]), .q(P));
    stage_reg #(.WIDTH(1),  .REG(CARRYOUTREG)) u_co (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(post[48]), .q(co_q));

    // pre-adder, operand muxes and post-adder; all selects come from the OPMODE stage
    always_comb begin
        pre   = op[OP_PRE_SUB] ? d_q - b0_q : d_q + b0_q;
        b1_in = op[OP_PRE_SEL] ? pre : b0_q;
        cin   = (CARRYINSEL == "CARRYIN") ? CARRYIN : op[OP_CARRY];
        x     = (op[1:0] == X_M) ? {12'd0, m_q} :
                (op[1:0] == X_P) ? P :
                (op[1:0] == X_DAB) ? {d_q[11:0], a1_q, b1_q} : 48'd0;
        z     = (op[3:2] == Z_PCIN) ? PCIN :
                (op[3:2] == Z_P) ? P :
                (op[3:2] == Z_C) ? c_q : 48'd0;
        post  = op[OP_POST_SUB] ? {1'b0, z} - ({1'b0, x} + {48'd0, cin_q})
                                : {1'b0, z} + {1'b0, x} + {48'd0, cin_q};
    end

    assign BCOUT     = b1_q;
    assign M         = m_q;
    assign PCOUT     = P;
    assign CARRYOUT  = co_q;
    assign CARRYOUTF = co_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb_dsp48a1_slice: directed scoreboard bench for the default-parameter slice
module tb_dsp48a1_slice;

    logic        CLK = 0;
    logic        RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int errors = 0;
    int checks = 0;
    string       tag_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] acc;

    dsp48a1_slice dut (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC),
        .RSTD(RSTD), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 CLK = ~CLK;

    task automatic push(input string tag, input logic [47:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [47:0] obs);
        string       t;
        logic [47:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic set_rst(input logic v);
        {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE} = {8{v}};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        set_rst(1'b0);
        {CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE} = 8'hFF;
        A = 0; B = 0; D = 0; C = 0; BCIN = 0; PCIN = 0; CARRYIN = 0; OPMODE = 0;

        push("rst_p", 48'd0); push("rst_m", 48'd0); push("rst_bcout", 48'd0);
        push("rst_co", 48'd0); push("rst_pcout", 48'd0); push("rst_cof", 48'd0);
        cycles(10);
        check(P); check(48'(M)); check(48'(BCOUT));
        check(48'(CARRYOUT)); check(PCOUT); check(48'(CARRYOUTF));
        set_rst(1'b1);

        OPMODE = 8'b00111101; D = 1000; B = 2000; A = 3; C = 10;
        push("preadd_mac_p", 48'd9011); push("preadd_mac_m", 48'd9000); push("preadd_mac_pcout", 48'd9011);
        cycles(10);
        check(P); check(48'(M)); check(PCOUT);

        OPMODE = 8'b01011101; D = 35; B = 15; A = 5; C = 50;
        push("presub_p", 48'd150); push("presub_bcout", 48'd20);
        cycles(10);
        check(P); check(48'(BCOUT));

        OPMODE = 8'b11001101; B = 15; A = 5; C = 250;
        push("postsub_p", 48'd175); push("postsub_bcout", 48'd15);
        cycles(10);
        check(P); check(48'(BCOUT));

        OPMODE = 8'b10001101; A = 0; C = 0; CARRYIN = 1;
        push("zero_p", 48'd0); push("zero_co", 48'd0);
        cycles(10);
        check(P); check(48'(CARRYOUT));

        B = 1; A = 1; C = 0;
        push("borrow_p", 48'hFFFF_FFFF_FFFF); push("borrow_co", 48'd1); push("borrow_cof", 48'd1);
        cycles(10);
        check(P); check(48'(CARRYOUT)); check(48'(CARRYOUTF));

        CARRYIN = 0;
        CEP = 0; OPMODE = 8'b00001001; A = 2; B = 3;
        cycles(6);
        RSTP = 0;
        cycles(1);
        RSTP = 1; CEP = 1;
        acc = 0;
        for (int k = 1; k <= 5; k++) begin
            acc = acc + 48'd6;
            push($sformatf("acc_%0d", k), acc);
            cycles(1);
            check(P);
        end

        CEP = 0;
        push("hold_p", acc);
        cycles(3);
        check(P);

        RSTP = 0;
        push("async_rst_p", 48'd0);
        #1;
        check(P);
        RSTP = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
